// File: rtl/dds_multi_line.sv
// Multi-channel line-segment DDS: per-channel phase accumulator, step and mode, registered signed sample and wrap strobe.
// Optional DDS_SYNC_LOAD_EN: retune is deferred to the channel's next wrap (phase-continuous); otherwise load is immediate.
module dds_multi_line #(
  parameter int CHANNELS   = 4,
  parameter int CH_W       = 2,
  parameter int PHASE_W    = 16,
  parameter int OUT_W      = 8,
  parameter int RESET_STEP = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      set,
  input  logic [CH_W-1:0]           ch_sel,
  input  logic [PHASE_W-1:0]        step_in,
  input  logic [1:0]                mode_in,
  output logic [CHANNELS*OUT_W-1:0] value,
  output logic [CHANNELS-1:0]       zero_address,
  output logic [CHANNELS-1:0]       load_pending
);

  typedef enum logic [1:0] {
    MODE_SAW = 2'd0,
    MODE_TRI = 2'd1,
    MODE_SQR = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  logic [PHASE_W-1:0] phase_q [CHANNELS];
  logic [PHASE_W-1:0] phase_d [CHANNELS];
  logic [PHASE_W-1:0] step_q  [CHANNELS];
  logic [PHASE_W-1:0] step_d  [CHANNELS];
  mode_e              mode_q  [CHANNELS];
  mode_e              mode_d  [CHANNELS];
  logic [OUT_W-1:0]   value_q [CHANNELS];
  logic [OUT_W-1:0]   value_d [CHANNELS];
  logic [CHANNELS-1:0] carry_q, carry_d;
  logic [CHANNELS-1:0] zero_q;
`ifdef DDS_SYNC_LOAD_EN
  logic [PHASE_W-1:0] pstep_q [CHANNELS];
  logic [PHASE_W-1:0] pstep_d [CHANNELS];
  mode_e              pmode_q [CHANNELS];
  mode_e              pmode_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
`endif

  function automatic logic [OUT_W-1:0] wave(input logic [OUT_W-1:0] t, input mode_e md);
    logic [OUT_W-1:0] two_r;
    logic [OUT_W-1:0] max_v;
    two_r = {1'b0, t[OUT_W-3:0], 1'b0};
    max_v = {1'b0, {(OUT_W-1){1'b1}}};
    wave  = '0;
    case (md)
      MODE_SAW: wave = t;
      MODE_TRI: begin
        case (t[OUT_W-1 -: 2])
          2'd0:    wave = two_r;
          2'd1:    wave = max_v - two_r;
          2'd2:    wave = -two_r;
          default: wave = two_r - max_v;
        endcase
      end
      MODE_SQR: wave = t[OUT_W-1] ? -max_v : max_v;
      default:  wave = '0;
    endcase
  endfunction

  always_comb begin : next_state
    logic               hit;
    logic               carry;
    logic [PHASE_W:0]   sum;
    hit     = 1'b0;
    carry   = 1'b0;
    sum     = '0;
    carry_d = '0;
`ifdef DDS_SYNC_LOAD_EN
    pend_d  = pend_q;
`endif
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hit        = set && (ch_sel == CH_W'(i));
      sum        = {1'b0, phase_q[i]} + {1'b0, step_q[i]};
      carry      = en && sum[PHASE_W];
      phase_d[i] = en ? sum[PHASE_W-1:0] : phase_q[i];
      step_d[i]  = step_q[i];
      mode_d[i]  = mode_q[i];
      value_d[i] = wave(phase_q[i][PHASE_W-1 -: OUT_W], mode_q[i]);
`ifdef DDS_SYNC_LOAD_EN
      pstep_d[i] = pstep_q[i];
      pmode_d[i] = pmode_q[i];
      // Commit earlier pending values first so a set on the wrap edge stays pending for the next wrap.
      if (carry && pend_q[i]) begin
        step_d[i] = pstep_q[i];
        mode_d[i] = pmode_q[i];
        pend_d[i] = 1'b0;
      end
      if (hit) begin
        pstep_d[i] = step_in;
        pmode_d[i] = mode_e'(mode_in);
        pend_d[i]  = 1'b1;
      end
`else
      if (hit) begin
        step_d[i]  = step_in;
        mode_d[i]  = mode_e'(mode_in);
        phase_d[i] = '0;
        carry      = 1'b0;
      end
`endif
      carry_d[i] = carry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        phase_q[i] <= '0;
        step_q[i]  <= PHASE_W'(RESET_STEP);
        mode_q[i]  <= MODE_TRI;
        value_q[i] <= '0;
`ifdef DDS_SYNC_LOAD_EN
        pstep_q[i] <= '0;
        pmode_q[i] <= MODE_TRI;
`endif
      end
      carry_q <= '0;
      zero_q  <= '0;
`ifdef DDS_SYNC_LOAD_EN
      pend_q  <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        phase_q[i] <= phase_d[i];
        step_q[i]  <= step_d[i];
        mode_q[i]  <= mode_d[i];
        value_q[i] <= value_d[i];
`ifdef DDS_SYNC_LOAD_EN
        pstep_q[i] <= pstep_d[i];
        pmode_q[i] <= pmode_d[i];
`endif
      end
      carry_q <= carry_d;
      // Second stage aligns the strobe with the first post-wrap sample.
      zero_q  <= carry_q;
`ifdef DDS_SYNC_LOAD_EN
      pend_q  <= pend_d;
`endif
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign value[g*OUT_W +: OUT_W] = value_q[g];
  end
  assign zero_address = zero_q;
`ifdef DDS_SYNC_LOAD_EN
  assign load_pending = pend_q;
`else
  assign load_pending = '0;
`endif

endmodule

// File: tb/tb_dds_multi_line.sv
// Directed self-checking bench for dds_multi_line (4-channel instance plus a 3-channel instance for out-of-range selects).
`timescale 1ns/1ps
module tb_dds_multi_line;
  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        set = 1'b0;
  logic        set3 = 1'b0;
  logic [1:0]  ch_sel = 2'd0;
  logic [1:0]  ch_sel3 = 2'd3;
  logic [15:0] step_in = 16'd0;
  logic [1:0]  mode_in = 2'd0;
  logic [31:0] value;
  logic [3:0]  zero_address, load_pending;
  logic [23:0] value3;
  logic [2:0]  zero3, pend3;

  int n_cmp = 0;
  int n_err = 0;

  int   ph[CH];
  int   st[CH];
  int   mo[CH];
  logic cr[CH];
  logic pd[CH];
`ifdef DDS_SYNC_LOAD_EN
  int   pst[CH];
  int   pmo[CH];
`endif
  logic [7:0] exp_val[CH];
  logic [3:0] exp_zero, exp_pend;

  always #5 clk = ~clk;

  dds_multi_line #(.CHANNELS(4), .CH_W(2), .PHASE_W(16), .OUT_W(8), .RESET_STEP(256)) dut (
    .clk(clk), .reset(reset), .en(en), .set(set), .ch_sel(ch_sel), .step_in(step_in),
    .mode_in(mode_in), .value(value), .zero_address(zero_address), .load_pending(load_pending)
  );

  dds_multi_line #(.CHANNELS(3), .CH_W(2), .PHASE_W(16), .OUT_W(8), .RESET_STEP(256)) dut3 (
    .clk(clk), .reset(reset), .en(en), .set(set3), .ch_sel(ch_sel3), .step_in(step_in),
    .mode_in(mode_in), .value(value3), .zero_address(zero3), .load_pending(pend3)
  );

  function automatic logic [7:0] wave_ref(input int p, input int m);
    int t, r;
    t = p / 256;
    r = 0;
    case (m)
      0: r = (t < 128) ? t : t - 256;
      1: begin
        if (t < 64)       r = 2 * t;
        else if (t < 128) r = 127 - 2 * (t - 64);
        else if (t < 192) r = -2 * (t - 128);
        else              r = -127 + 2 * (t - 192);
      end
      2: r = (t < 128) ? 127 : -127;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ph[c] = 0; st[c] = 256; mo[c] = 1; cr[c] = 1'b0; pd[c] = 1'b0;
      exp_val[c] = 8'd0;
    end
    exp_zero = '0;
    exp_pend = '0;
  endtask

  task automatic model_edge(input logic e, input logic s, input logic [1:0] sel, input int stp, input int md);
    int   sum;
    logic c_now;
    for (int c = 0; c < CH; c++) begin
      exp_val[c]  = wave_ref(ph[c], mo[c]);
      exp_zero[c] = cr[c];
      sum   = ph[c] + st[c];
      c_now = e && (sum >= 65536);
      if (e) ph[c] = sum % 65536;
`ifdef DDS_SYNC_LOAD_EN
      if (c_now && pd[c]) begin st[c] = pst[c]; mo[c] = pmo[c]; pd[c] = 1'b0; end
      if (s && int'(sel) == c) begin pst[c] = stp; pmo[c] = md; pd[c] = 1'b1; end
`else
      if (s && int'(sel) == c) begin st[c] = stp; mo[c] = md; ph[c] = 0; c_now = 1'b0; end
`endif
      cr[c] = c_now;
      exp_pend[c] = pd[c];
    end
  endtask

  task automatic cyc(input logic s, input logic [1:0] sel, input int stp, input int md);
    set = s; ch_sel = sel; step_in = 16'(stp); mode_in = 2'(md);
    @(posedge clk);
    model_edge(en, s, sel, stp, md);
    #1;
    set = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #2;
    n_cmp++; if (value !== '0) begin n_err++; $display("FAIL reset_value got=%h want=0", value); end
    n_cmp++; if (zero_address !== '0) begin n_err++; $display("FAIL reset_zero got=%b want=0", zero_address); end
    n_cmp++; if (load_pending !== '0) begin n_err++; $display("FAIL reset_pend got=%b want=0", load_pending); end
    n_cmp++; if (value3 !== '0) begin n_err++; $display("FAIL reset_value3 got=%h want=0", value3); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    en = 1'b1;
    model_reset();
  endtask

  task automatic test_triangle();
    for (int n = 1; n <= 520; n++) begin
      cyc(1'b0, 2'd0, 0, 0);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (value[c*8 +: 8] !== exp_val[c]) begin
          n_err++; $display("FAIL tri edge=%0d ch%0d value got=%0d want=%0d", n, c, $signed(value[c*8 +: 8]), $signed(exp_val[c]));
        end
      end
      n_cmp++; if (zero_address !== exp_zero) begin n_err++; $display("FAIL tri edge=%0d zero got=%b want=%b", n, zero_address, exp_zero); end
      n_cmp++; if (load_pending !== exp_pend) begin n_err++; $display("FAIL tri edge=%0d pend got=%b want=%b", n, load_pending, exp_pend); end
    end
    n_cmp++; if (value[7:0] !== 8'd14) begin n_err++; $display("FAIL tri_final ch0 got=%0d want=14", $signed(value[7:0])); end
  endtask

  task automatic test_square_load();
    cyc(1'b1, 2'd1, 512, 2);
    for (int n = 0; n < 300; n++) begin
      cyc(1'b0, 2'd0, 0, 0);
`ifndef DDS_SYNC_LOAD_EN
      if (n == 0) begin
        n_cmp++; if (value[15:8] !== 8'd127) begin n_err++; $display("FAIL sq_first got=%0d want=127", $signed(value[15:8])); end
      end
      if (n == 64) begin
        n_cmp++; if (value[15:8] !== 8'h81) begin n_err++; $display("FAIL sq_neg got=%0d want=-127", $signed(value[15:8])); end
      end
`endif
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (value[c*8 +: 8] !== exp_val[c]) begin
          n_err++; $display("FAIL square n=%0d ch%0d value got=%0d want=%0d", n, c, $signed(value[c*8 +: 8]), $signed(exp_val[c]));
        end
      end
      n_cmp++; if (zero_address !== exp_zero) begin n_err++; $display("FAIL square n=%0d zero got=%b want=%b", n, zero_address, exp_zero); end
      n_cmp++; if (load_pending !== exp_pend) begin n_err++; $display("FAIL square n=%0d pend got=%b want=%b", n, load_pending, exp_pend); end
    end
  endtask

  task automatic test_saw_load();
    cyc(1'b1, 2'd3, 1024, 0);
    for (int n = 0; n < 200; n++) begin
      cyc(1'b0, 2'd0, 0, 0);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (value[c*8 +: 8] !== exp_val[c]) begin
          n_err++; $display("FAIL saw n=%0d ch%0d value got=%0d want=%0d", n, c, $signed(value[c*8 +: 8]), $signed(exp_val[c]));
        end
      end
      n_cmp++; if (zero_address !== exp_zero) begin n_err++; $display("FAIL saw n=%0d zero got=%b want=%b", n, zero_address, exp_zero); end
    end
  endtask

  task automatic test_freeze_invalid();
    set3 = 1'b1;
    cyc(1'b0, 2'd0, 0, 3);
    set3 = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (n == 10) en = 1'b0;
      if (n == 20) en = 1'b1;
      cyc(1'b0, 2'd0, 0, 0);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (value3[c*8 +: 8] !== exp_val[0]) begin
          n_err++; $display("FAIL sel_oob n=%0d ch%0d value got=%0d want=%0d", n, c, $signed(value3[c*8 +: 8]), $signed(exp_val[0]));
        end
      end
      n_cmp++; if (zero3 !== {3{exp_zero[0]}}) begin n_err++; $display("FAIL sel_oob n=%0d zero got=%b want=%b", n, zero3, {3{exp_zero[0]}}); end
      n_cmp++; if (pend3 !== 3'b000) begin n_err++; $display("FAIL sel_oob n=%0d pend got=%b want=000", n, pend3); end
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (value[c*8 +: 8] !== exp_val[c]) begin
          n_err++; $display("FAIL freeze n=%0d ch%0d value got=%0d want=%0d", n, c, $signed(value[c*8 +: 8]), $signed(exp_val[c]));
        end
      end
      n_cmp++; if (zero_address !== exp_zero) begin n_err++; $display("FAIL freeze n=%0d zero got=%b want=%b", n, zero_address, exp_zero); end
    end
    cyc(1'b1, 2'd2, 0, 1);
    for (int n = 0; n < 300; n++) begin
      cyc(1'b0, 2'd0, 0, 0);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (value[c*8 +: 8] !== exp_val[c]) begin
          n_err++; $display("FAIL step0 n=%0d ch%0d value got=%0d want=%0d", n, c, $signed(value[c*8 +: 8]), $signed(exp_val[c]));
        end
      end
      n_cmp++; if (zero_address !== exp_zero) begin n_err++; $display("FAIL step0 n=%0d zero got=%b want=%b", n, zero_address, exp_zero); end
      n_cmp++; if (load_pending !== exp_pend) begin n_err++; $display("FAIL step0 n=%0d pend got=%b want=%b", n, load_pending, exp_pend); end
    end
  endtask

  task automatic test_async_reset();
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (value !== '0) begin n_err++; $display("FAIL areset_value got=%h want=0", value); end
    n_cmp++; if (zero_address !== '0) begin n_err++; $display("FAIL areset_zero got=%b want=0", zero_address); end
    n_cmp++; if (load_pending !== '0) begin n_err++; $display("FAIL areset_pend got=%b want=0", load_pending); end
    n_cmp++; if (value3 !== '0) begin n_err++; $display("FAIL areset_value3 got=%h want=0", value3); end
    @(posedge clk);
    #4 reset = 1'b1;
    model_reset();
    for (int n = 1; n <= 300; n++) begin
      cyc(1'b0, 2'd0, 0, 0);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (value[c*8 +: 8] !== exp_val[c]) begin
          n_err++; $display("FAIL rerun edge=%0d ch%0d value got=%0d want=%0d", n, c, $signed(value[c*8 +: 8]), $signed(exp_val[c]));
        end
      end
      n_cmp++; if (zero_address !== exp_zero) begin n_err++; $display("FAIL rerun edge=%0d zero got=%b want=%b", n, zero_address, exp_zero); end
      n_cmp++; if (value3[7:0] !== exp_val[0]) begin n_err++; $display("FAIL rerun3 edge=%0d got=%0d want=%0d", n, $signed(value3[7:0]), $signed(exp_val[0])); end
    end
  endtask

  task automatic test_retune();
    for (int n = 0; n < 500; n++) begin
      if (n == 0)       cyc(1'b1, 2'd2, 1024, 0);
      else if (n == 40) cyc(1'b1, 2'd2, 512, 1);
      else              cyc(1'b0, 2'd0, 0, 0);
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (value[c*8 +: 8] !== exp_val[c]) begin
          n_err++; $display("FAIL retune n=%0d ch%0d value got=%0d want=%0d", n, c, $signed(value[c*8 +: 8]), $signed(exp_val[c]));
        end
      end
      n_cmp++; if (zero_address !== exp_zero) begin n_err++; $display("FAIL retune n=%0d zero got=%b want=%b", n, zero_address, exp_zero); end
      n_cmp++; if (load_pending !== exp_pend) begin n_err++; $display("FAIL retune n=%0d pend got=%b want=%b", n, load_pending, exp_pend); end
    end
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_square_load();
    test_saw_load();
    test_freeze_invalid();
    test_async_reset();
    test_retune();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
